// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the prefetching fetch stage: bus request/response
// structs, the fetch-to-decode payload and the fetch FSM state encoding.
package fetch_prefetch_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    // Queue depth used when the fetch stage is instantiated.
    localparam int FETCH_QUEUE_DEPTH = 4;

    // Instructions are 4-byte aligned; redirect targets are forced onto that grid.
    localparam u64 PC_ALIGN_MASK = ~64'd3;

    typedef struct packed {
        u64   addr;
        logic valid;
    } ibus_req_t;

    typedef struct packed {
        u64   data;
        logic data_ok;
    } ibus_resp_t;

    typedef struct packed {
        u64   pc;
        u32   raw_instr;
        u64   iresp_data;
        logic valid;
        logic bubble;
    } fetch_data_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_t;

    function automatic u64 align_pc(input u64 pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch_data_t with synchronous flush.
// The caller never pushes when full or pops when empty.
module fetch_queue
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_data_t              push_data,
    output fetch_data_t              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_data_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the array has no reset; an entry is only observed once count says it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential-PC fetch stage with one outstanding ibus
// request, a DEPTH-entry instruction queue and redirect handling.
// Define FETCH_STATS_EN to get live push/drop counters on stat_*.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int DEPTH       = FETCH_QUEUE_DEPTH,
    parameter u64 RESET_PC    = 64'h8000_0000,
    parameter int INSTR_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  u64          redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t dataF,
    output u64          fetch_pc,
    output u64          stat_fetched,
    output u64          stat_dropped
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    u64            pc_q, pc_d;
    u64            addr_q, addr_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    fetch_data_t   push_data;

    // A redirect squashes both the incoming response and any hand-off to decode.
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign push       = (state_q == REQ) && iresp.data_ok && !redirect_valid;
    assign count_next = count + CW'(push) - CW'(pop);

    assign push_data = '{pc:         pc_q,
                         raw_instr:  iresp.data[31:0],
                         iresp_data: iresp.data,
                         valid:      1'b1,
                         bubble:     1'b0};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (dataF),
        .count     (count)
    );

    // Next-state, next-PC and next bus address.
    // NOTE: every target gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid || (count < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    state_d = iresp.data_ok ? REQ : DISCARD;
                end else if (iresp.data_ok) begin
                    state_d = (count_next < DEPTH_C) ? REQ : IDLE;
                    pc_d    = pc_q + u64'(INSTR_BYTES);
                end
            end
            DISCARD: begin
                if (iresp.data_ok) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) pc_d = align_pc(redirect_pc);
        // The stale request must keep its address on the bus until it completes.
        addr_d = (state_d == DISCARD) ? addr_q : pc_d;
    end

    // State, PC and registered bus address.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    assign ireq.valid = (state_q != IDLE);
    assign ireq.addr  = addr_q;
    assign fetch_pc   = pc_q;

`ifdef FETCH_STATS_EN
    u64   fetched_q;
    u64   dropped_q;
    logic drop;

    // A response is dropped when it belongs to a request squashed by a redirect.
    assign drop = iresp.data_ok &&
                  ((state_q == DISCARD) || ((state_q == REQ) && redirect_valid));

    // Free-running event counters, wrapping at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (push) fetched_q <= fetched_q + 64'd1;
            if (drop) dropped_q <= dropped_q + 64'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_dropped = dropped_q;
`else
    assign stat_fetched = '0;
    assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: a bus responder, a scoreboard of
// expected queue entries, and directed scenarios followed by a random phase.
module tb_fetch_prefetch;
    import fetch_prefetch_pkg::*;

    localparam int DEPTH    = 4;
    localparam u64 RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp = '0;
    logic        redirect_valid;
    u64          redirect_pc;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t dataF;
    u64          fetch_pc;
    u64          stat_fetched;
    u64          stat_dropped;

    fetch_prefetch #(
        .DEPTH       (DEPTH),
        .RESET_PC    (RESET_PC),
        .INSTR_BYTES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dataF          (dataF),
        .fetch_pc       (fetch_pc),
        .stat_fetched   (stat_fetched),
        .stat_dropped   (stat_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        u64 pc;
        u64 data;
    } exp_t;

    exp_t sbq[$];
    u64   pop_log[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   n_pushes     = 0;
    u64   exp_pc;
    u64   disc_addr;
    logic discarding;
    u64   exp_fetched;
    u64   exp_dropped;
    int   bus_mode;   // 0 stall, 1 always ready, 2 random, 3 data_ok forced high

    task automatic check(input string tag, input u64 got, input u64 want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic u64 bus_data(input u64 a);
        return {a[31:0] ^ 32'hA5A5_0F0F, ~a[31:0] + 32'd7};
    endfunction

    task automatic model_reset();
        sbq.delete();
        pop_log.delete();
        exp_pc      = RESET_PC;
        discarding  = 1'b0;
        disc_addr   = '0;
        exp_fetched = '0;
        exp_dropped = '0;
    endtask

    // Instruction bus: data is a function of the address being requested.
    always @(negedge clk) begin
        #1;
        iresp.data = bus_data(ireq.addr);
        case (bus_mode)
            0:       iresp.data_ok = 1'b0;
            1:       iresp.data_ok = ireq.valid;
            2:       iresp.data_ok = ireq.valid && ($urandom_range(0, 2) != 0);
            default: iresp.data_ok = 1'b1;
        endcase
    end

    // Monitor/scoreboard, evaluated late in each cycle when all inputs are settled.
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            check("out_valid", u64'(out_valid), u64'(sbq.size() != 0));
`ifdef FETCH_STATS_EN
            check("stat_fetched", stat_fetched, exp_fetched);
            check("stat_dropped", stat_dropped, exp_dropped);
`else
            check("stat_fetched_tied", stat_fetched, 64'd0);
            check("stat_dropped_tied", stat_dropped, 64'd0);
`endif
            if (ireq.valid)
                check("ireq_addr", ireq.addr, discarding ? disc_addr : exp_pc);
            if (out_valid && out_ready && !redirect_valid && sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                pop_log.push_back(dataF.pc);
                check("dataF_pc", dataF.pc, e.pc);
                check("dataF_raw", u64'(dataF.raw_instr), u64'(e.data[31:0]));
                check("dataF_resp", dataF.iresp_data, e.data);
                check("dataF_vb", u64'({dataF.valid, dataF.bubble}), 64'd2);
            end
            if (ireq.valid && iresp.data_ok) begin
                if (discarding) begin
                    discarding = 1'b0;
                    exp_dropped++;
                end else if (redirect_valid) begin
                    exp_dropped++;
                end else begin
                    exp_t e;
                    e.pc   = exp_pc;
                    e.data = bus_data(exp_pc);
                    sbq.push_back(e);
                    exp_pc += 64'd4;
                    exp_fetched++;
                    n_pushes++;
                end
            end
            if (redirect_valid) begin
                sbq.delete();
                if (ireq.valid && !iresp.data_ok && !discarding) begin
                    discarding = 1'b1;
                    disc_addr  = exp_pc;
                end
                exp_pc = redirect_pc & ~64'd3;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", u64'(out_valid), 64'd0);
        check("rst_ireq_valid", u64'(ireq.valid), 64'd0);
        check("rst_ireq_addr", ireq.addr, RESET_PC);
        check("rst_fetch_pc", fetch_pc, RESET_PC);
        check("rst_stats", stat_fetched | stat_dropped, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_req(input int budget, input string tag);
        int c = 0;
        while (!ireq.valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, u64'(ireq.valid), 64'd1);
    endtask

    task automatic wait_pushes(input int n, input int budget, input string tag);
        int start = n_pushes;
        int c = 0;
        while (n_pushes - start < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, u64'(n_pushes - start >= n), 64'd1);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int start = pop_log.size();
        int c = 0;
        while (pop_log.size() - start < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, u64'(pop_log.size() - start >= n), 64'd1);
    endtask

    task automatic pulse_redirect(input u64 target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        u64 d0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        bus_mode       = 1;
        model_reset();

        // Streaming fetch from reset with decode always ready.
        out_ready = 1'b1;
        do_reset();
        wait_req(10, "a_first_req");
        check("a_first_addr", ireq.addr, 64'h8000_0000);
        wait_pops(3, 30, "a_three_pops");
        check("a_pc0", pop_log[0], 64'h8000_0000);
        check("a_pc1", pop_log[1], 64'h8000_0004);
        check("a_pc2", pop_log[2], 64'h8000_0008);

        // Fill the queue with decode stalled, then release one entry.
        out_ready = 1'b0;
        do_reset();
        wait_pushes(DEPTH, 20, "b_fill");
        repeat (3) @(negedge clk);
        check("b_full_ireq_valid", u64'(ireq.valid), 64'd0);
        check("b_full_out_valid", u64'(out_valid), 64'd1);
        check("b_full_pushes", exp_fetched, u64'(DEPTH));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        wait_req(5, "b_refill_req");
        check("b_refill_addr", ireq.addr, 64'h8000_0010);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Redirect while a request is stalled: stale response is discarded.
        bus_mode = 0;
        @(negedge clk);
        wait_req(10, "c_req");
        d0 = exp_dropped;
        pulse_redirect(64'h8000_1002);
        check("c_discard_valid", u64'(ireq.valid), 64'd1);
        repeat (2) @(negedge clk);
        bus_mode = 1;
        wait_pops(1, 20, "c_pop");
        check("c_new_pc", pop_log[pop_log.size() - 1], 64'h8000_1000);
        check("c_dropped", exp_dropped - d0, 64'd1);

        // Redirect together with data_ok and out_ready on a non-empty queue.
        out_ready = 1'b0;
        wait_pushes(2, 20, "d_fill");
        out_ready = 1'b1;
        wait_req(10, "d_req");
        pulse_redirect(64'h8000_2000);
        check("d_flushed", u64'(out_valid), 64'd0);
        check("d_target_addr", ireq.addr, 64'h8000_2000);
        wait_pops(1, 20, "d_pop");
        check("d_new_pc", pop_log[pop_log.size() - 1], 64'h8000_2000);

        // Two redirects while discarding: one drop, fetch resumes at the last target.
        bus_mode = 0;
        @(negedge clk);
        wait_req(10, "e_req");
        d0 = exp_dropped;
        pulse_redirect(64'h100);
        pulse_redirect(64'h200);
        check("e_discard_valid", u64'(ireq.valid), 64'd1);
        repeat (2) @(negedge clk);
        bus_mode = 1;
        wait_pops(1, 20, "e_pop");
        check("e_new_pc", pop_log[pop_log.size() - 1], 64'h200);
        check("e_dropped", exp_dropped - d0, 64'd1);

        // Async reset mid-request at count 3, with data_ok held high around reset.
        out_ready = 1'b0;
        do_reset();
        wait_pushes(3, 20, "f_fill3");
        check("f_in_req", u64'(ireq.valid), 64'd1);
        bus_mode = 3;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("f_async_out_valid", u64'(out_valid), 64'd0);
        check("f_async_ireq_valid", u64'(ireq.valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wait_req(5, "f_restart_req");
        check("f_restart_addr", ireq.addr, RESET_PC);
        bus_mode  = 1;
        out_ready = 1'b1;
        wait_pops(1, 20, "f_pop");
        check("f_first_pc", pop_log[0], RESET_PC);

        // Random bus stalls, decode back-pressure and redirects.
        bus_mode = 2;
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {32'h0, $urandom};
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        bus_mode       = 1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised successor to the single-entry fetch stage; next-generation front end.
- Runs a sequential PC, issues one outstanding ibus request at a time and buffers returned instructions in a DEPTH-entry queue.
- Hands instructions to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush and discard of an in-flight response; sits between pcselect/redirect logic and decode.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 64'h8000_0000, fetch PC after reset.
- INSTR_BYTES, 4, PC increment per fetched instruction.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- ireq  output  ibus_req_t  instruction bus request (addr, valid)
- iresp  input  ibus_resp_t  instruction bus response (data, data_ok)
- redirect_valid  input  1  redirect fetch this cycle
- redirect_pc  input  64  redirect target
- out_valid  output  1  dataF holds a valid instruction
- out_ready  input  1  decode accepts dataF this cycle
- dataF  output  fetch_data_t  head entry: pc, raw_instr, iresp_data, valid=1, bubble=0
- fetch_pc  output  64  PC of next/outstanding request, debug
- stat_fetched  output  64  instructions pushed (see Optional Feature)
- stat_dropped  output  64  responses discarded (see Optional Feature)

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (async): fetch_pc=RESET_PC, queue empty, state=IDLE, ireq.valid=0, ireq.addr=RESET_PC, out_valid=0, stats=0.
- States: IDLE, REQ, DISCARD.
- ireq.valid=1 in REQ and DISCARD. ireq.addr is registered: fetch_pc in REQ, the old address in DISCARD.
- Bus rule: addr held stable with valid=1 until data_ok.
- IDLE: if count<DEPTH, go to REQ next cycle; otherwise stay.
- REQ, data_ok=1, no redirect:
  - push {pc=fetch_pc, raw_instr=iresp.data[31:0], iresp_data}; fetch_pc += INSTR_BYTES (64-bit wrap).
  - Next state is REQ if count_next<DEPTH (pop counted), else IDLE.
  - Entry to REQ requires count<DEPTH, so a push never overflows.
- REQ, data_ok=0: hold.
- Redirect has priority over push and pop in the same cycle:
  - queue flushed, so out_valid=0 next cycle;
  - fetch_pc = {redirect_pc[63:2],2'b00};
  - from IDLE, or REQ with data_ok=1 (data dropped, stat_dropped+1): next state REQ;
  - from REQ with data_ok=0: next state DISCARD.
- DISCARD: wait for data_ok, drop the data (stat_dropped+1), then go to REQ with the new fetch_pc. A redirect during DISCARD updates fetch_pc and stays in DISCARD.
- Output:
  - out_valid = (count!=0); dataF = head entry.
  - Pop when out_valid && out_ready && !redirect_valid.
  - Push and pop in the same cycle leave count unchanged.
- Latency: data_ok in cycle N gives out_valid in N+1 (empty queue). No bypass.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
- Reset mid-request: state returns to IDLE immediately; a late data_ok after reset is ignored (IDLE does not push).

Optional Feature:
- FETCH_STATS_EN defined: stat_fetched increments on every push; stat_dropped increments on every discarded response; both 64-bit, wrapping, cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- pipes package: fetch_data_t (existing), fetch_state_t enum {IDLE,REQ,DISCARD}.
- common package: u64/u32, ibus_req_t/ibus_resp_t (existing), FETCH_QUEUE_DEPTH constant used at instantiation.
- One sub-module, fetch_queue: parametrised FIFO (push, pop, flush, count, head), DEPTH entries of fetch_data_t.

Test Plan:
- Reset, bus returns data_ok every cycle, out_ready=1 -> first ireq.addr=0x8000_0000; dataF.pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; raw_instr matches bus data.
- out_ready=0, bus always ready, DEPTH=4 -> exactly 4 pushes; state IDLE, ireq.valid=0, count=4. Then out_ready=1 for 1 cycle -> one pop, next request at 0x8000_0010.
- Redirect to 0x8000_1002 while REQ with data_ok=0 -> DISCARD; old addr held; old data dropped; next request addr 0x8000_1000; queue empty; stat_dropped=1 if FETCH_STATS_EN.
- Redirect in the same cycle as data_ok and out_ready -> no push, no pop, queue empty next cycle, next ireq.addr=target.
- Two redirects (0x100, then 0x200) during DISCARD -> single drop, then fetch at 0x200.
- Async reset asserted mid-REQ with queue at count=3 -> out_valid=0 and ireq.valid=0 without a clock edge; after release, fetch restarts at 0x8000_0000.
